mnacidpro_seq: RTL and testbench

- Clocked protocol sequencer that drives the control valves and the 3-phase peristaltic pump of an N-channel nucleic-acid processor.
- It is the next generation of the static SIZE-channel processor top level. Instead of exposing raw ctrl lines to the tester, it runs bead-load, lyse, mix, wash and elute for each enabled collect channel in turn.
- Sits between the host/tester and the chip's ctrl pins.

---
 rtl/mnacidpro_seq.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_mnacidpro_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mnacidpro_seq.sv
// mnacidpro_seq: protocol sequencer for an N-channel nucleic-acid processor.
// For each enabled collect channel, in ascending order, it runs
// BEAD -> LYSE -> MIX -> WASH -> ELUTE and drives the valves and a 3-phase
// peristaltic pump. Zero-length phases and masked channels cost no cycles.
// Optional FLUSH phase after every ELUTE: define MNACIDPRO_SEQ_FLUSH_EN.
module mnacidpro_seq #(
  parameter int SIZE     = 6,
  parameter int DWELL_W  = 16,
  parameter int PUMP_DIV = 4,
  localparam int CW      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [SIZE-1:0]    chan_mask,
  input  logic [DWELL_W-1:0] load_cycles,
  input  logic [DWELL_W-1:0] mix_cycles,
  input  logic [DWELL_W-1:0] wash_cycles,
  input  logic [DWELL_W-1:0] elute_cycles,
`ifdef MNACIDPRO_SEQ_FLUSH_EN
  input  logic [DWELL_W-1:0] flush_cycles,
  output logic               flush_act,
`endif
  output logic               lysis_ctrl,
  output logic               wash_ctrl,
  output logic               elute_ctrl,
  output logic               dead_end_ctrl,
  output logic               vertical_ctrl,
  output logic               horiz_ctrl,
  output logic               waste_ctrl,
  output logic               bead_ctrl,
  output logic               loop_exit_ctrl,
  output logic               bead_trap_ctrl,
  output logic               collect_ctrl,
  output logic [SIZE-1:0]    collect_sel,
  output logic [2:0]         pump,
  output logic [CW-1:0]      cur_chan,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

`ifdef MNACIDPRO_SEQ_FLUSH_EN
  localparam int NPH = 6;
`else
  localparam int NPH = 5;
`endif
  localparam int DIVW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

  // valve bit positions inside valve_reg
  localparam int V_LYSIS = 0, V_WASH = 1, V_ELUTE = 2, V_DEAD = 3, V_VERT = 4, V_HORIZ = 5;
  localparam int V_WASTE = 6, V_BEAD = 7, V_LEXIT = 8, V_BTRAP = 9, V_COLL = 10;

  typedef enum logic [3:0] {
    S_IDLE, S_BEAD, S_LYSE, S_MIX, S_WASH, S_ELUTE,
`ifdef MNACIDPRO_SEQ_FLUSH_EN
    S_FLUSH,
`endif
    S_DONE, S_ABORT
  } state_t;

  state_t                      state_reg, state_next;
  logic [CW-1:0]               chan_reg, chan_next;
  logic [DWELL_W-1:0]          dwell_reg, dwell_next;
  logic [2:0]                  step_reg, step_next;
  logic [DIVW-1:0]             div_reg, div_next;
  logic [SIZE-1:0]             mask_reg, mask_sel;
  logic [NPH-1:0][DWELL_W-1:0] dur_in, dur_reg, dur_sel;
  logic [NPH-1:0]              nz;
  logic                        active, enter, ph_found, ch_found;
  logic [2:0]                  cur_ph, ph_nxt, ph_first, tgt_ph;
  logic [CW-1:0]               ch_nxt;
  logic [10:0]                 valve_reg, valve_next;
  logic [SIZE-1:0]             sel_reg, sel_next;
  logic [2:0]                  pump_reg, pump_next;
  logic                        busy_reg, done_reg, aborted_reg;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
  logic                        flush_reg, flush_next;
`endif

  function automatic logic is_phase(state_t s);
    case (s)
      S_BEAD, S_LYSE, S_MIX, S_WASH, S_ELUTE: return 1'b1;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
      S_FLUSH: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] ph_index(state_t s);
    case (s)
      S_LYSE:  return 3'd1;
      S_MIX:   return 3'd2;
      S_WASH:  return 3'd3;
      S_ELUTE: return 3'd4;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
      S_FLUSH: return 3'd5;
`endif
      default: return 3'd0;
    endcase
  endfunction

  function automatic state_t ph_state(logic [2:0] p);
    case (p)
      3'd0:    return S_BEAD;
      3'd1:    return S_LYSE;
      3'd2:    return S_MIX;
      3'd3:    return S_WASH;
      3'd4:    return S_ELUTE;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
      3'd5:    return S_FLUSH;
`endif
      default: return S_IDLE;
    endcase
  endfunction

  function automatic logic [2:0] pump_pat(logic [2:0] s);
    case (s)
      3'd0:    return 3'b100;
      3'd1:    return 3'b110;
      3'd2:    return 3'b010;
      3'd3:    return 3'b011;
      3'd4:    return 3'b001;
      3'd5:    return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  // BEAD and LYSE share load_cycles; phase index order matches the sequence
  assign dur_in[0] = load_cycles;
  assign dur_in[1] = load_cycles;
  assign dur_in[2] = mix_cycles;
  assign dur_in[3] = wash_cycles;
  assign dur_in[4] = elute_cycles;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
  assign dur_in[5] = flush_cycles;
`endif

  // In IDLE the start decision must look at the live inputs, later at the shadows
  assign mask_sel = (state_reg == S_IDLE) ? chan_mask : mask_reg;
  assign dur_sel  = (state_reg == S_IDLE) ? dur_in : dur_reg;
  assign active   = is_phase(state_reg);
  assign cur_ph   = ph_index(state_reg);

  for (genvar gi = 0; gi < NPH; gi++) begin : g_nz
    assign nz[gi] = (dur_sel[gi] != '0);
  end

  // Shadow copy of the run configuration, captured when a start is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg <= '0;
      dur_reg  <= '0;
    end else if (state_reg == S_IDLE && start) begin
      mask_reg <= chan_mask;
      dur_reg  <= dur_in;
    end
  end

  // Look-ahead: next non-empty phase of this channel, first non-empty phase, next enabled channel
  always_comb begin
    ph_found = 1'b0;
    ph_nxt   = '0;
    ph_first = '0;
    ch_found = 1'b0;
    ch_nxt   = '0;
    for (int p = NPH - 1; p >= 0; p--) begin
      if (active && nz[p] && (p > int'(cur_ph))) begin
        ph_found = 1'b1;
        ph_nxt   = 3'(p);
      end
      if (nz[p]) ph_first = 3'(p);
    end
    for (int c = SIZE - 1; c >= 0; c--) begin
      if (mask_sel[c] && (!active || c > int'(chan_reg))) begin
        ch_found = 1'b1;
        ch_nxt   = CW'(c);
      end
    end
  end

  // Next-state logic: dwell countdown, pump stepping, phase/channel chaining, abort
  always_comb begin
    state_next = state_reg;
    chan_next  = chan_reg;
    dwell_next = dwell_reg;
    step_next  = step_reg;
    div_next   = div_reg;
    enter      = 1'b0;
    tgt_ph     = '0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (ch_found && (|nz)) begin
            enter     = 1'b1;
            tgt_ph    = ph_first;
            chan_next = ch_nxt;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE, S_ABORT: state_next = S_IDLE;
      default: begin
        if (dwell_reg != '0) begin
          dwell_next = dwell_reg - DWELL_W'(1);
          if (div_reg == DIVW'(PUMP_DIV - 1)) begin
            div_next  = '0;
            step_next = (step_reg == 3'd5) ? 3'd0 : step_reg + 3'd1;
          end else begin
            div_next = div_reg + DIVW'(1);
          end
        end else if (ph_found) begin
          enter  = 1'b1;
          tgt_ph = ph_nxt;
        end else if (ch_found && (|nz)) begin
          enter     = 1'b1;
          tgt_ph    = ph_first;
          chan_next = ch_nxt;
        end else begin
          state_next = S_DONE;
        end
      end
    endcase
    if (enter) begin
      state_next = ph_state(tgt_ph);
      dwell_next = dur_sel[tgt_ph] - DWELL_W'(1);
      step_next  = '0;
      div_next   = '0;
    end
    if (abort && state_reg != S_IDLE && state_reg != S_ABORT) state_next = S_ABORT;
    // cur_chan only reports a channel while a phase is running
    if (!is_phase(state_next)) chan_next = '0;
  end

  // Output decode from the next state so every output comes straight from a flop
  always_comb begin
    valve_next   = '0;
    sel_next     = '0;
    pump_next    = '0;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
    flush_next   = 1'b0;
`endif
    case (state_next)
      S_BEAD:  begin valve_next[V_BEAD] = 1'b1; valve_next[V_BTRAP] = 1'b1; valve_next[V_WASTE] = 1'b1; end
      S_LYSE:  begin valve_next[V_LYSIS] = 1'b1; valve_next[V_HORIZ] = 1'b1; valve_next[V_DEAD] = 1'b1; end
      S_MIX:   begin valve_next[V_VERT] = 1'b1; valve_next[V_HORIZ] = 1'b1; end
      S_WASH:  begin
        valve_next[V_WASH]  = 1'b1; valve_next[V_BTRAP] = 1'b1;
        valve_next[V_LEXIT] = 1'b1; valve_next[V_WASTE] = 1'b1;
      end
      S_ELUTE: begin
        valve_next[V_ELUTE] = 1'b1; valve_next[V_BTRAP] = 1'b1;
        valve_next[V_LEXIT] = 1'b1; valve_next[V_COLL]  = 1'b1;
        sel_next = SIZE'(1) << chan_next;
      end
`ifdef MNACIDPRO_SEQ_FLUSH_EN
      S_FLUSH: begin
        flush_next = 1'b1;
        valve_next[V_WASTE] = 1'b1; valve_next[V_LEXIT] = 1'b1; valve_next[V_BTRAP] = 1'b1;
      end
`endif
      default: ;
    endcase
    if (is_phase(state_next)) pump_next = pump_pat(step_next);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      chan_reg    <= '0;
      dwell_reg   <= '0;
      step_reg    <= '0;
      div_reg     <= '0;
      valve_reg   <= '0;
      sel_reg     <= '0;
      pump_reg    <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
      flush_reg   <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      chan_reg    <= chan_next;
      dwell_reg   <= dwell_next;
      step_reg    <= step_next;
      div_reg     <= div_next;
      valve_reg   <= valve_next;
      sel_reg     <= sel_next;
      pump_reg    <= pump_next;
      busy_reg    <= (state_next != S_IDLE);
      done_reg    <= (state_next == S_DONE);
      aborted_reg <= (state_next == S_ABORT);
`ifdef MNACIDPRO_SEQ_FLUSH_EN
      flush_reg   <= flush_next;
`endif
    end
  end

  assign lysis_ctrl     = valve_reg[V_LYSIS];
  assign wash_ctrl      = valve_reg[V_WASH];
  assign elute_ctrl     = valve_reg[V_ELUTE];
  assign dead_end_ctrl  = valve_reg[V_DEAD];
  assign vertical_ctrl  = valve_reg[V_VERT];
  assign horiz_ctrl     = valve_reg[V_HORIZ];
  assign waste_ctrl     = valve_reg[V_WASTE];
  assign bead_ctrl      = valve_reg[V_BEAD];
  assign loop_exit_ctrl = valve_reg[V_LEXIT];
  assign bead_trap_ctrl = valve_reg[V_BTRAP];
  assign collect_ctrl   = valve_reg[V_COLL];
  assign collect_sel    = sel_reg;
  assign pump           = pump_reg;
  assign cur_chan       = chan_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign aborted        = aborted_reg;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
  assign flush_act      = flush_reg;
`endif

endmodule

// File: tb/tb_mnacidpro_seq.sv
// tb_mnacidpro_seq: cycle-exact check of mnacidpro_seq against a trace model.
// The model expands each run into a list of expected output words, one per
// cycle, from the channel mask and phase durations.
// Honours MNACIDPRO_SEQ_FLUSH_EN when the design is built with it.
module tb_mnacidpro_seq;
  localparam int SIZE = 6, DWELL_W = 16, PUMP_DIV = 4;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
  localparam int NPH = 6;
`else
  localparam int NPH = 5;
`endif
  typedef logic [26:0] vec_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [SIZE-1:0] chan_mask = '0;
  logic [DWELL_W-1:0] load_cycles = '0, mix_cycles = '0, wash_cycles = '0, elute_cycles = '0, flush_cycles = '0;
  logic lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl;
  logic waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl, flush_act_w;
  logic [SIZE-1:0] collect_sel;
  logic [2:0] pump, cur_chan;
  logic busy, done, aborted;
  int total = 0, bad = 0;
  vec_t exp_q[$];
  vec_t obs;

  always #5 clk = ~clk;

  mnacidpro_seq #(.SIZE(SIZE), .DWELL_W(DWELL_W), .PUMP_DIV(PUMP_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .chan_mask(chan_mask),
    .load_cycles(load_cycles), .mix_cycles(mix_cycles), .wash_cycles(wash_cycles),
    .elute_cycles(elute_cycles),
`ifdef MNACIDPRO_SEQ_FLUSH_EN
    .flush_cycles(flush_cycles), .flush_act(flush_act_w),
`endif
    .lysis_ctrl(lysis_ctrl), .wash_ctrl(wash_ctrl), .elute_ctrl(elute_ctrl),
    .dead_end_ctrl(dead_end_ctrl), .vertical_ctrl(vertical_ctrl), .horiz_ctrl(horiz_ctrl),
    .waste_ctrl(waste_ctrl), .bead_ctrl(bead_ctrl), .loop_exit_ctrl(loop_exit_ctrl),
    .bead_trap_ctrl(bead_trap_ctrl), .collect_ctrl(collect_ctrl), .collect_sel(collect_sel),
    .pump(pump), .cur_chan(cur_chan), .busy(busy), .done(done), .aborted(aborted)
  );
`ifndef MNACIDPRO_SEQ_FLUSH_EN
  assign flush_act_w = 1'b0;
`endif

  assign obs = {flush_act_w, lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl,
                horiz_ctrl, waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl,
                collect_sel, pump, cur_chan, busy, done, aborted};

  // Expected output word for phase ph (-1 = none) of channel ch, k cycles into the phase
  function automatic vec_t mk(int ph, int ch, int k, bit b, bit d, bit a);
    logic [2:0] pat [6];
    logic fl, lys, wsh, elu, dead, vert, hor, wst, bd, lex, btr, col;
    logic [SIZE-1:0] sel;
    logic [2:0] pmp, cc;
    pat = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    {fl, lys, wsh, elu, dead, vert, hor, wst, bd, lex, btr, col} = '0;
    sel = '0; pmp = '0; cc = '0;
    case (ph)
      0: begin bd = 1; btr = 1; wst = 1; end
      1: begin lys = 1; hor = 1; dead = 1; end
      2: begin vert = 1; hor = 1; end
      3: begin wsh = 1; btr = 1; lex = 1; wst = 1; end
      4: begin elu = 1; btr = 1; lex = 1; col = 1; sel = SIZE'(1 << ch); end
      5: begin fl = 1; wst = 1; lex = 1; btr = 1; end
      default: ;
    endcase
    if (ph >= 0) begin
      pmp = pat[(k / PUMP_DIV) % 6];
      cc  = 3'(ch);
    end
    return {fl, lys, wsh, elu, dead, vert, hor, wst, bd, lex, btr, col, sel, pmp, cc, b, d, a};
  endfunction

  task automatic chk(input vec_t e, input string tag);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // One full run. kind: 0 normal, 1 abort at trace index at, 2 reset at trace index at
  task automatic run(input logic [SIZE-1:0] m, input int ld, input int mx, input int ws,
                     input int el, input int fl, input int kind, input int at,
                     input bit ab_with_start, input string name);
    int durs [6];
    int n;
    bit cut;
    durs = '{ld, ld, mx, ws, el, fl};
    exp_q.delete();
    for (int c = 0; c < SIZE; c++)
      if (m[c])
        for (int p = 0; p < NPH; p++)
          for (int k = 0; k < durs[p]; k++) exp_q.push_back(mk(p, c, k, 1, 0, 0));
    n = exp_q.size();
    $display("run %s mask=%b load=%0d mix=%0d wash=%0d elute=%0d flush=%0d kind=%0d at=%0d cycles=%0d",
             name, m, ld, mx, ws, el, fl, kind, at, n);
    @(negedge clk);
    chan_mask = m; load_cycles = 16'(ld); mix_cycles = 16'(mx); wash_cycles = 16'(ws);
    elute_cycles = 16'(el); flush_cycles = 16'(fl);
    start = 1'b1; abort = ab_with_start;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    // latched config must not follow the inputs any more
    chan_mask = SIZE'($urandom); load_cycles = 16'($urandom_range(0, 9));
    mix_cycles = 16'($urandom_range(0, 9)); wash_cycles = 16'($urandom_range(0, 9));
    elute_cycles = 16'($urandom_range(0, 9)); flush_cycles = 16'($urandom_range(0, 9));
    cut = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk(exp_q[i], $sformatf("%s_cyc%0d", name, i));
      if (kind != 0 && i == at) begin
        start = 1'b0;
        if (kind == 1) begin
          abort = 1'b1; @(negedge clk); abort = 1'b0;
          chk(mk(-1, 0, 0, 1, 0, 1), {name, "_abort"});
        end else begin
          rst = 1'b1; @(negedge clk); rst = 1'b0;
          chk('0, {name, "_rst"});
        end
        @(negedge clk);
        chk('0, {name, "_idle_after_cut"});
        cut = 1'b1;
        break;
      end
      // a start while busy must be ignored
      if (kind == 0) start = (i == 1 && n > 3);
      @(negedge clk);
    end
    start = 1'b0;
    if (!cut) begin
      chk(mk(-1, 0, 0, 1, 1, 0), {name, "_done"});
      @(negedge clk);
      chk('0, {name, "_idle"});
    end
  endtask

  initial begin
    int m, ld, mx, ws, el, fl, kind, at, n;
    repeat (2) @(negedge clk);
    chk('0, "reset");
    rst = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk('0, "abort_in_idle");
    run(6'b000001, 2, 2, 2, 2, 0, 0, 0, 0, "basic");
    run(6'b100100, 2, 2, 2, 3, 0, 0, 0, 0, "two_chan");
    run(6'b000001, 3, 0, 0, 5, 0, 0, 0, 1, "skip_mix_wash");
    run(6'b000010, 1, 20, 1, 30, 0, 0, 0, 0, "long_pump");
    run(6'b000001, 2, 2, 4, 2, 0, 1, 8, 0, "abort_wash3");
    run(6'b000001, 2, 2, 4, 2, 0, 0, 0, 0, "after_abort");
    run(6'b000011, 2, 2, 2, 2, 0, 2, 8, 0, "rst_elute");
    run(6'b000000, 2, 2, 2, 2, 0, 0, 0, 0, "mask_zero");
    run(6'b101010, 0, 0, 0, 0, 0, 0, 0, 0, "all_zero_dur");
    run(6'b010001, 1, 1, 1, 1, 5, 0, 0, 0, "flush5");
    for (int r = 0; r < 12; r++) begin
      m  = $urandom_range(0, 63);
      ld = $urandom_range(0, 3); mx = $urandom_range(0, 26); ws = $urandom_range(0, 3);
      el = $urandom_range(0, 4); fl = $urandom_range(0, 3);
      n = 0;
      for (int c = 0; c < SIZE; c++) if (m[c]) n += 2 * ld + mx + ws + el + ((NPH == 6) ? fl : 0);
      kind = (r % 3 == 2 && n > 0) ? 1 + (r % 2) : 0;
      at = (n > 0) ? $urandom_range(0, n - 1) : 0;
      run(6'(m), ld, mx, ws, el, fl, kind, at, 1'(r % 2), $sformatf("rand%0d", r));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
